// File: rtl/cjb_alu_pkg.sv
// Shared cjbRISC ALU definitions: shift-unit function selects, CNVZ flag bit
// positions and the sequential shift unit's state encoding.
package cjb_alu_pkg;

    localparam logic [1:0] SL_SHLL = 2'b00;
    localparam logic [1:0] SL_RLC  = 2'b01;
    localparam logic [1:0] SL_SHLA = 2'b10;
    localparam logic [1:0] SL_PASS = 2'b11;

    localparam int CNVZ_C = 3;
    localparam int CNVZ_N = 2;
    localparam int CNVZ_V = 1;
    localparam int CNVZ_Z = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sl_state_t;

endpackage

// File: rtl/cjb_8bit_sl_step_v.sv
// One left-shift step of the shift unit: SHLL, RLC (rotate through carry) or SHLA.
// Purely combinational, no backpressure; the pass-through select leaves the state unchanged.
module cjb_8bit_sl_step_v
    import cjb_alu_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic [WIDTH-1:0] work_in,
    input  logic             c_in,
    input  logic             v_in,
    input  logic [1:0]       func_sel,
    output logic [WIDTH-1:0] work_out,
    output logic             c_out,
    output logic             v_out
);

    always_comb begin
        work_out = work_in;
        c_out    = c_in;
        v_out    = v_in;
        if (func_sel != SL_PASS) begin
            work_out = {work_in[WIDTH-2:0], (func_sel == SL_RLC) ? c_in : 1'b0};
            c_out    = work_in[WIDTH-1];
            // Sticky overflow: any step that changes the sign bit sets V.
            if (func_sel == SL_SHLA)
                v_out = v_in | (work_in[WIDTH-1] ^ work_in[WIDTH-2]);
        end
    end

endmodule

// File: rtl/cjb_8bit_sl_seq_unit.sv
// Multi-cycle shift/rotate-left ALU sub-unit with start/done handshake; K+1 cycles
// Start-to-Done (1 for K=0/pass), Start ignored while busy. CJB_SL_SINGLE_CYCLE_EN: Done always at t+1.
module cjb_8bit_sl_seq_unit
    import cjb_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K_W   = 2
)
(
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [1:0]       Func_Sel,
    input  logic [WIDTH-1:0] Operand_X,
    input  logic [WIDTH-1:0] Operand_Y,
    input  logic [K_W-1:0]   Const_K,
    input  logic             cin,
    output logic             SL_Busy,
    output logic             SL_Done,
    output logic [WIDTH-1:0] SL_Result,
    output logic [3:0]       SL_CNVZ
);

    localparam int MAX_K = (1 << K_W) - 1;

    sl_state_t        state;
    logic [WIDTH-1:0] work;
    logic             c_work;
    logic             v_work;
    logic [1:0]       func_q;
    logic [K_W-1:0]   count;

    logic [WIDTH-1:0] step_work;
    logic             step_c;
    logic             step_v;
    logic [WIDTH-1:0] fin_work;
    logic             fin_c;
    logic             fin_v;
    logic [3:0]       flags;

`ifdef CJB_SL_SINGLE_CYCLE_EN
    localparam logic SINGLE_CYCLE = 1'b1;

    logic [WIDTH-1:0] ch_work [0:MAX_K];
    logic             ch_c    [0:MAX_K];
    logic             ch_v    [0:MAX_K];

    assign ch_work[0] = work;
    assign ch_c[0]    = c_work;
    assign ch_v[0]    = v_work;

    // Stage i holds the state after i steps; count selects the tap, so the
    // whole shift is resolved in the DONE cycle from the latched operands.
    for (genvar i = 0; i < MAX_K; i++) begin : g_chain
        cjb_8bit_sl_step_v #(.WIDTH(WIDTH)) u_step (
            .work_in  (ch_work[i]),
            .c_in     (ch_c[i]),
            .v_in     (ch_v[i]),
            .func_sel (func_q),
            .work_out (ch_work[i+1]),
            .c_out    (ch_c[i+1]),
            .v_out    (ch_v[i+1])
        );
    end

    assign step_work = ch_work[1];
    assign step_c    = ch_c[1];
    assign step_v    = ch_v[1];
    assign fin_work  = ch_work[count];
    assign fin_c     = ch_c[count];
    assign fin_v     = ch_v[count];
`else
    localparam logic SINGLE_CYCLE = 1'b0;

    cjb_8bit_sl_step_v #(.WIDTH(WIDTH)) u_step (
        .work_in  (work),
        .c_in     (c_work),
        .v_in     (v_work),
        .func_sel (func_q),
        .work_out (step_work),
        .c_out    (step_c),
        .v_out    (step_v)
    );

    assign fin_work = work;
    assign fin_c    = c_work;
    assign fin_v    = v_work;
`endif

    always_comb begin
        flags         = '0;
        flags[CNVZ_C] = fin_c;
        flags[CNVZ_N] = fin_work[WIDTH-1];
        flags[CNVZ_V] = fin_v;
        flags[CNVZ_Z] = (fin_work == '0);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            work      <= '0;
            c_work    <= 1'b0;
            v_work    <= 1'b0;
            func_q    <= SL_SHLL;
            count     <= '0;
            SL_Busy   <= 1'b0;
            SL_Done   <= 1'b0;
            SL_Result <= '0;
            SL_CNVZ   <= '0;
        end else begin
            SL_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        // Pass-through rides the same path with zero steps and C=V=0.
                        func_q  <= Func_Sel;
                        work    <= (Func_Sel == SL_PASS) ? Operand_Y : Operand_X;
                        c_work  <= (Func_Sel == SL_PASS) ? 1'b0 : cin;
                        v_work  <= 1'b0;
                        count   <= (Func_Sel == SL_PASS) ? '0 : Const_K;
                        SL_Busy <= 1'b1;
                        if (SINGLE_CYCLE || Const_K == '0 || Func_Sel == SL_PASS)
                            state <= DONE;
                        else
                            state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work   <= step_work;
                    c_work <= step_c;
                    v_work <= step_v;
                    count  <= count - 1'b1;
                    if (count == K_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    SL_Result <= fin_work;
                    SL_CNVZ   <= flags;
                    SL_Done   <= 1'b1;
                    SL_Busy   <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    SL_Busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cjb_8bit_sl_seq_unit.sv
// Bench for the shift-left unit: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_cjb_8bit_sl_seq_unit;
    import cjb_alu_pkg::*;

    logic       Clock;
    logic       Resetn;
    logic       Start;
    logic [1:0] Func_Sel;
    logic [7:0] Operand_X;
    logic [7:0] Operand_Y;
    logic [1:0] Const_K;
    logic       cin;
    logic       SL_Busy;
    logic       SL_Done;
    logic [7:0] SL_Result;
    logic [3:0] SL_CNVZ;

    int compared   = 0;
    int mismatched = 0;

    cjb_8bit_sl_seq_unit #(.WIDTH(8), .K_W(2)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Start     (Start),
        .Func_Sel  (Func_Sel),
        .Operand_X (Operand_X),
        .Operand_Y (Operand_Y),
        .Const_K   (Const_K),
        .cin       (cin),
        .SL_Busy   (SL_Busy),
        .SL_Done   (SL_Done),
        .SL_Result (SL_Result),
        .SL_CNVZ   (SL_CNVZ)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {C,N,V,Z,result}: shifts as multiplication, RLC as a 9-bit rotate,
    // SHLA overflow as "the top K+1 bits of X are not all equal".
    function automatic logic [11:0] model(input logic [1:0] f, input logic [7:0] x,
                                          input logic [7:0] y, input int k, input logic ci);
        int r;
        int nine;
        int top;
        logic [7:0] res;
        logic c;
        logic v;
        res = y;
        c   = 1'b0;
        v   = 1'b0;
        case (f)
            SL_PASS: res = y;
            SL_RLC: begin
                nine = int'(ci) * 256 + int'(x);
                r    = ((nine << k) | (nine >> (9 - k))) & 511;
                res  = r[7:0];
                c    = r[8];
            end
            default: begin
                r   = int'(x) * (1 << k);
                res = r[7:0];
                c   = (k == 0) ? ci : r[8];
                if (f == SL_SHLA && k > 0) begin
                    top = int'(x) >> (7 - k);
                    v   = !(top == 0 || top == ((1 << (k + 1)) - 1));
                end
            end
        endcase
        return {c, res[7], v, (res == 8'h00), res};
    endfunction

    task automatic run_op(input string tag, input logic [1:0] f, input logic [7:0] x,
                          input logic [7:0] y, input logic [1:0] k, input logic ci,
                          input bit poke, input bit use_fixed, input logic [11:0] fixed);
        logic [11:0] exp;
        int lat;
        int n;
        int busy_cyc;
        bit seen;
        exp = use_fixed ? fixed : model(f, x, y, int'(k), ci);
`ifdef CJB_SL_SINGLE_CYCLE_EN
        lat = 1;
`else
        lat = (f == SL_PASS || k == 2'd0) ? 1 : int'(k) + 1;
`endif
        Func_Sel  = f;
        Operand_X = x;
        Operand_Y = y;
        Const_K   = k;
        cin       = ci;
        Start     = 1'b1;
        @(posedge Clock); #1;
        Start     = 1'b0;
        // Operands may change freely once sampled.
        Func_Sel  = 2'($urandom);
        Operand_X = 8'($urandom);
        Operand_Y = 8'($urandom);
        Const_K   = 2'($urandom);
        cin       = 1'($urandom);
        n = 0;
        busy_cyc = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            if (SL_Busy) busy_cyc++;
            if (poke && SL_Busy) begin
                Start     = 1'b1;
                Operand_X = 8'hFF;
            end
            @(posedge Clock); #1;
            n++;
            Start = 1'b0;
            if (SL_Done) seen = 1'b1;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(lat));
        check({tag, " result"}, 32'(SL_Result), 32'(exp[7:0]));
        check({tag, " cnvz"}, 32'(SL_CNVZ), 32'(exp[11:8]));
        @(posedge Clock); #1;
        check({tag, " done_pulse"}, 32'(SL_Done), 32'd0);
        check({tag, " idle_busy"}, 32'(SL_Busy), 32'd0);
        check({tag, " result_held"}, 32'(SL_Result), 32'(exp[7:0]));
    endtask

    initial begin
        bit spurious;
        Resetn    = 1'b1;
        Start     = 1'b0;
        Func_Sel  = SL_SHLL;
        Operand_X = 8'h00;
        Operand_Y = 8'h00;
        Const_K   = 2'd0;
        cin       = 1'b0;
        #2 Resetn = 1'b0;
        #2;
        check("reset busy", 32'(SL_Busy), 32'd0);
        check("reset done", 32'(SL_Done), 32'd0);
        check("reset result", 32'(SL_Result), 32'd0);
        check("reset cnvz", 32'(SL_CNVZ), 32'd0);
        @(posedge Clock); #1;
        Resetn = 1'b1;
        @(posedge Clock); #1;

        run_op("shll_81_k1", SL_SHLL, 8'h81, 8'h00, 2'd1, 1'b0, 1'b0, 1'b1, {4'b1000, 8'h02});
        run_op("rlc_80_k3_poke", SL_RLC, 8'h80, 8'h00, 2'd3, 1'b1, 1'b1, 1'b1, {4'b0000, 8'h06});
        run_op("shla_40_k1", SL_SHLA, 8'h40, 8'h00, 2'd1, 1'b0, 1'b0, 1'b1, {4'b0110, 8'h80});
        run_op("shla_20_k3", SL_SHLA, 8'h20, 8'h00, 2'd3, 1'b0, 1'b0, 1'b1, {4'b1011, 8'h00});
        run_op("shll_00_k0", SL_SHLL, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1, {4'b1001, 8'h00});
        run_op("pass_5a", SL_PASS, 8'hC3, 8'h5A, 2'd2, 1'b1, 1'b0, 1'b1, {4'b0000, 8'h5A});

        // Reset in the middle of a shift.
        Func_Sel  = SL_RLC;
        Operand_X = 8'h80;
        Const_K   = 2'd3;
        cin       = 1'b1;
        Start     = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(posedge Clock); #1;
        Resetn = 1'b0;
        #1;
        check("midreset busy", 32'(SL_Busy), 32'd0);
        check("midreset done", 32'(SL_Done), 32'd0);
        check("midreset result", 32'(SL_Result), 32'd0);
        check("midreset cnvz", 32'(SL_CNVZ), 32'd0);
        @(posedge Clock); #1;
        Resetn = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clock); #1;
            if (SL_Done || SL_Busy) spurious = 1'b1;
        end
        check("post_reset quiet", 32'(spurious), 32'd0);

        run_op("after_reset", SL_SHLA, 8'h1F, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0, 12'h000);

        for (int i = 0; i < 40; i++) begin
            run_op("random", 2'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                   1'($urandom), 1'($urandom), 1'b0, 12'h000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cjb_8bit_sl_seq_unit.md
Name: cjb_8bit_sl_seq_unit

Overview:
Multi-cycle shift-left/rotate-left unit for the cjbRISC ALU, the left-direction counterpart of the existing combinational shift-right unit. It shifts Operand_X left by Const_K places, one bit per clock, using a start/done handshake. It produces an 8-bit result and CNVZ status bits in the same format as the other ALU sub-units. The ALU sequencer selects its result when SL_Done is asserted.

Parameters:
WIDTH, 8, data path width in bits.
K_W, 2, width of the shift-amount field; maximum shift is 2^K_W-1.

Ports:
Clock  input  1  system clock, rising edge.
Resetn  input  1  asynchronous active-low reset.
Start  input  1  one-cycle request; operands are sampled on this edge.
Func_Sel  input  2  00 SHLL, 01 RLC, 10 SHLA, 11 pass Operand_Y.
Operand_X  input  WIDTH  value to shift.
Operand_Y  input  WIDTH  pass-through value.
Const_K  input  K_W  shift amount.
cin  input  1  carry in; feeds RLC.
SL_Busy  output  1  high while an operation is in progress.
SL_Done  output  1  one-cycle pulse when the result is valid.
SL_Result  output  WIDTH  registered result; held until the next accepted Start.
SL_CNVZ  output  4  {C,N,V,Z}; registered and held with SL_Result.

Behaviour:
- Reset (asynchronous, Resetn=0):
  - State goes to IDLE.
  - SL_Busy=0, SL_Done=0, SL_Result=0x00, SL_CNVZ=4'b0000.
  - Any operation in flight is abandoned.
- State machine, states IDLE, SHIFT, DONE:
  - IDLE & Start: latch X, Y, Func_Sel, Const_K and cin into working registers; count=Const_K; C_work=cin; V_work=0.
    - Next state is SHIFT if count!=0 and Func_Sel!=11, otherwise DONE.
  - SHIFT: each cycle, one shift step, then count-1. Leave for DONE when count reaches 1 and that final step is executed.
  - DONE: drive SL_Result and SL_CNVZ from the working registers, pulse SL_Done for one cycle, return to IDLE.
- SL_Busy=1 in SHIFT and DONE.
- Start while SL_Busy=1 is ignored; no queueing.
- Shift step per function:
  - SHLL: work={work[6:0],0}; C_work=work[7].
  - RLC: work={work[6:0],C_work}; C_work=work[7] (9-bit rotate through carry).
  - SHLA: same as SHLL; V_work|=work[7]^work[6], i.e. sticky if any step changes the sign bit.
- Latency (Start sampled at edge t):
  - SL_Done is high in cycle t+K+1 when Func_Sel!=11.
  - SL_Done is high in cycle t+1 when K=0 or Func_Sel=11.
- Flags at DONE:
  - C=C_work. For K=0 this equals cin.
  - N=result[7].
  - V=V_work; nonzero only for SHLA.
  - Z=(result==0).
  - Pass-through (Func_Sel=11): result=Y, C=0, V=0, N and Z computed from Y.
- Input changes after Start do not affect an operation in flight.
- Start asserted in the same cycle as DONE is ignored, because the unit is still busy. It is accepted in the following IDLE cycle.

Optional Feature:
CJB_SL_SINGLE_CYCLE_EN
- Defined: the full K-place shift and all flags are computed combinationally from the latched operands. SHIFT is skipped and SL_Done always occurs at t+1. Results and flags are bit-identical to the iterative mode.
- Undefined: iterative one-bit-per-cycle operation, as described in Behaviour.

Decomposition:
- Shared package cjb_alu_pkg holds:
  - function-select constants: SL_SHLL=2'b00, SL_RLC=2'b01, SL_SHLA=2'b10, SL_PASS=2'b11;
  - CNVZ bit index constants;
  - state encoding IDLE/SHIFT/DONE.
- One sub-module, cjb_8bit_sl_step_v: combinational single-bit left-shift step taking {work, C_work, V_work, Func_Sel} and producing the next values. The FSM instantiates it, and it is chained K times in single-cycle mode.

Test Plan:
- SHLL, X=0x81, K=1, Start at t → SL_Done at t+2; SL_Result=0x02, CNVZ=1000.
- RLC, X=0x80, cin=1, K=3 → SL_Busy for 4 cycles, SL_Done at t+4; SL_Result=0x06, CNVZ=0000.
- SHLA, X=0x40, K=1 → SL_Result=0x80, CNVZ=0110. Also SHLA, X=0x20, K=3 → 0x00, CNVZ=1011 (sticky V).
- SHLL, X=0x00, K=0, cin=1 → SL_Done at t+1; SL_Result=0x00, CNVZ=1001. Pass, Y=0x5A → 0x5A, CNVZ=0000 at t+1.
- Start re-pulsed with X=0xFF during busy RLC, K=3 → ignored; original result delivered, then a new Start in IDLE is accepted.
- Resetn low mid-SHIFT → SL_Busy=0, SL_Done=0, SL_Result=0x00, SL_CNVZ=0 immediately. After release no SL_Done pulses until a new Start.
